lfsr_seq_checker: RTL

- Downstream consumer of the 16-bit Fibonacci LFSR pattern generator.
- Takes a word stream that is meant to follow the LFSR sequence (taps 15,13,12,10; next = {v[14:0], v[15]^v[13]^v[12]^v[10]}).
- Self-synchronises to the stream, then flags and counts every word that departs from the predicted sequence.
- Used as the receive-side checker in loopback and link BIST paths.

---
 rtl/lfsr_seq_checker.sv | 84 ++++++++
 1 files changed

// File: rtl/lfsr_seq_checker.sv
// lfsr_seq_checker: self-synchronising checker for a 16-bit Fibonacci LFSR word stream
module lfsr_seq_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int ERR_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [15:0]          in_data,
  input  logic                 clear_errs,
  output logic                 locked,
  output logic [1:0]           state,
  output logic                 err_pulse,
  output logic [ERR_WIDTH-1:0] err_count
);
  typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} st_t;
  localparam logic [3:0] lock_n = 4'(LOCK_COUNT);
  localparam logic [3:0] loss_n = 4'(LOSS_COUNT);
  st_t st, st_n;
  logic [15:0] pred, pred_n;
  logic [3:0] match_cnt, match_n, miss_cnt, miss_n;
  logic err, hit, nz;
  function automatic logic [15:0] nxt(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction
  assign state = st;
  always_comb begin
    st_n = st;
    pred_n = pred;
    match_n = match_cnt;
    miss_n = miss_cnt;
    err = 1'b0;
    hit = in_data == pred;
    nz = |in_data;
    if (in_valid)
      case (st)
        HUNT: if (nz) begin
          pred_n = nxt(in_data);
          match_n = 4'd0;
          st_n = VERIFY;
        end
        VERIFY: if (hit) begin
          pred_n = nxt(in_data);
          match_n = match_cnt + 4'd1;
          if (match_n == lock_n) begin
            st_n = LOCKED;
            miss_n = 4'd0;
          end
        end else if (nz) begin
          pred_n = nxt(in_data);
          match_n = 4'd0;
        end else st_n = HUNT;
        LOCKED: begin
          pred_n = nxt(pred);
          if (hit) miss_n = 4'd0;
          else begin
            err = 1'b1;
            miss_n = miss_cnt + 4'd1;
            st_n = miss_n == loss_n ? HUNT : LOCKED;
          end
        end
        default: st_n = HUNT;
      endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st <= HUNT;
      pred <= '0;
      match_cnt <= '0;
      miss_cnt <= '0;
      locked <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      st <= st_n;
      pred <= pred_n;
      match_cnt <= match_n;
      miss_cnt <= miss_n;
      locked <= st_n == LOCKED;
      err_pulse <= err;
      err_count <= clear_errs ? '0 : (err && !(&err_count)) ? err_count + 1'b1 : err_count;
    end
endmodule
